keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving clocks per scan tick (1 kHz at 50 MHz).
REQ-002 The block SHALL have parameter DEBOUNCE_TICKS, default 20, giving consecutive stable ticks required to accept a press or release.
REQ-003 The block SHALL have port i_clock, input, 1 bit: single system clock, rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_Columna, input, 4 bits: keypad column lines, active-low, externally pulled up, asynchronous to i_clock.
REQ-006 The block SHALL have port o_Fila, output, 4 bits: keypad row drive, active-low one-hot.
REQ-007 The block SHALL have port o_Tecla, output, 4 bits: code of the last accepted key, equal to row*4+col.
REQ-008 The block SHALL have port o_Valida, output, 1 bit: one-cycle pulse when a press is accepted.
REQ-009 The block SHALL have port o_Presionada, output, 1 bit: level, high while an accepted key is held.

Function
REQ-010 i_Columna SHALL pass through a two-flop synchronizer; all decisions use the synchronized value.
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; the tick is asserted for the one cycle at count SCAN_DIV-1.
REQ-012 The FSM SHALL have states SCAN, DEB_PRESS, HELD and DEB_RELEASE; transitions are evaluated only on tick cycles.
REQ-013 In SCAN with all synchronized columns high at tick, o_Fila SHALL rotate 1110->1101->1011->0111->1110.
REQ-014 In SCAN with any column low at tick, the FSM SHALL capture the row index and the lowest-index low column, hold o_Fila unchanged and go to DEB_PRESS with the stable count at 1.
REQ-015 In DEB_PRESS, on each tick with the captured column low, the stable count SHALL increment; on reaching DEBOUNCE_TICKS, o_Tecla SHALL load the code, o_Valida SHALL pulse for exactly one cycle, and the FSM SHALL go to HELD.
REQ-016 In DEB_PRESS, a tick with the captured column high SHALL return the FSM to SCAN, rotate o_Fila, and produce no o_Valida.
REQ-017 In HELD, o_Presionada SHALL be 1 and o_Fila frozen; a tick with the captured column high SHALL go to DEB_RELEASE with the release count at 1.
REQ-018 In DEB_RELEASE, ticks with the column high SHALL increment the count, and at DEBOUNCE_TICKS the FSM SHALL go to SCAN, clear o_Presionada and rotate o_Fila; a tick with the column low SHALL return the FSM to HELD.
REQ-019 o_Presionada SHALL be 1 in both HELD and DEB_RELEASE.
REQ-020 Additional keys pressed while in DEB_PRESS, HELD or DEB_RELEASE SHALL be ignored (no rollover); only the captured column is monitored.
REQ-021 o_Tecla SHALL retain its value until the next accepted press.

Reset
REQ-022 While i_reset=0, the block SHALL asynchronously force: o_Fila=1110, o_Tecla=0, o_Valida=0, o_Presionada=0, state=SCAN, prescaler=0, all debounce counts=0, synchronizer flops=1111.
REQ-023 Reset asserted in any state SHALL abort the operation in progress without emitting o_Valida; scanning SHALL resume from row 0 on the first tick after release.

Structure
REQ-024 A shared package keypad_pkg SHALL hold the FSM state enumeration and the row-ring initial constant 4'b1110.
REQ-025 The prescaler SHALL be a sub-module scan_tick_gen (parameter SCAN_DIV, outputs tick); all other logic resides in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-026 No key pressed for 64 cycles -> o_Fila cycles 1110,1101,1011,0111 with each value held 4 cycles; o_Valida never asserts.
REQ-027 Key at row 2, col 1 held (i_Columna=1101 only when o_Fila=1011) -> exactly one o_Valida pulse with o_Tecla=9; o_Presionada=1 and o_Fila stays 1011 until release.
REQ-028 Press bouncing high on the second debounce tick -> no o_Valida; the FSM returns to SCAN and o_Fila advances.
REQ-029 Columns 0 and 2 low together on row 1 -> o_Tecla=4; after release plus 3 high ticks, o_Presionada=0 and o_Fila advances to 1011.
REQ-030 i_reset pulsed low during DEB_PRESS -> outputs take their reset values immediately; no o_Valida; scanning restarts at 1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner.
//   kp_state_e  : scanner FSM state encoding
//   ROW_INIT    : row-drive ring value after reset (row 0 driven low)
//   COL_IDLE    : column value seen when no key is pressed (pull-ups)
//   low_index   : index of the lowest zero bit of a 4-bit active-low vector
//   rotate_row  : advance the active-low one-hot row ring to the next row
//   key_code    : row*4+col code of a key
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } kp_state_e;

  localparam logic [3:0] ROW_INIT = 4'b1110;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Lowest-index zero wins; an all-ones vector returns 0 (callers only use
  // the result when at least one bit is low).
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

  // 1110 -> 1101 -> 1011 -> 0111 -> 1110
  function automatic logic [3:0] rotate_row(input logic [3:0] fila);
    return {fila[2:0], fila[3]};
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage : keypad_pkg

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running prescaler producing the keypad scan tick.
//   SCAN_DIV : clocks per tick; the counter runs 0..SCAN_DIV-1 and wraps
// Ports
//   i_clock  : system clock, rising edge
//   i_reset  : asynchronous active-low reset (counter returns to 0)
//   tick     : high for the single cycle in which the count is SCAN_DIV-1
// -----------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic tick
);

  // A divider of 1 still needs a 1-bit counter; it simply ticks every cycle.
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);

endmodule : scan_tick_gen

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row per tick, debounces a single
// key and reports it. No rollover: once a key is captured only its column is
// watched until it is released.
//   SCAN_DIV       : clocks per scan tick
//   DEBOUNCE_TICKS : consecutive stable ticks to accept a press or release
// Ports
//   i_clock      : system clock, rising edge
//   i_reset      : asynchronous active-low reset
//   i_Columna    : column lines, active-low, asynchronous to i_clock
//   o_Fila       : row drive, active-low one-hot
//   o_Tecla      : code (row*4+col) of the last accepted key
//   o_Valida     : one-cycle pulse when a press is accepted
//   o_Presionada : high while an accepted key is held (HELD / DEB_RELEASE)
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_Columna,
  output logic [3:0] o_Fila,
  output logic [3:0] o_Tecla,
  output logic       o_Valida,
  output logic       o_Presionada
);

  // Counter must be able to hold DEBOUNCE_TICKS itself.
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS);
  // With a single-tick debounce the first sighting already completes it.
  localparam bit DEB_IMMEDIATE = (DEBOUNCE_TICKS <= 1);

  // ---------------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] col_meta_q;
  logic [3:0] col_sync_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      col_meta_q <= COL_IDLE;
      col_sync_q <= COL_IDLE;
    end else begin
      col_meta_q <= i_Columna;
      col_sync_q <= col_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan tick
  // ---------------------------------------------------------------------------
  logic tick;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .tick    (tick)
  );

  // ---------------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------------
  kp_state_e     state_q,   state_d;
  logic [3:0]    fila_q,    fila_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    tecla_q,   tecla_d;
  logic          valida_q,  valida_d;

  logic          captured_low;
  logic          any_low;
  logic [DW-1:0] deb_cnt_inc;

  assign captured_low = ~col_sync_q[col_idx_q];
  assign any_low      = (col_sync_q != COL_IDLE);
  assign deb_cnt_inc  = deb_cnt_q + DEB_ONE;

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_SCAN;
      fila_q    <= ROW_INIT;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      deb_cnt_q <= '0;
      tecla_q   <= 4'd0;
      valida_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fila_q    <= fila_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      deb_cnt_q <= deb_cnt_d;
      tecla_q   <= tecla_d;
      valida_q  <= valida_d;
    end
  end

  // Next-state logic; nothing moves except on tick cycles.
  always_comb begin
    state_d   = state_q;
    fila_d    = fila_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    deb_cnt_d = deb_cnt_q;
    tecla_d   = tecla_q;
    valida_d  = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            // Row stays driven so the captured column keeps reading this key.
            row_idx_d = low_index(fila_q);
            col_idx_d = low_index(col_sync_q);
            if (DEB_IMMEDIATE) begin
              tecla_d   = key_code(low_index(fila_q), low_index(col_sync_q));
              valida_d  = 1'b1;
              deb_cnt_d = '0;
              state_d   = ST_HELD;
            end else begin
              deb_cnt_d = DEB_ONE;
              state_d   = ST_DEB_PRESS;
            end
          end else begin
            fila_d = rotate_row(fila_q);
          end
        end

        ST_DEB_PRESS: begin
          if (captured_low) begin
            if (deb_cnt_inc == DEB_LAST) begin
              tecla_d   = key_code(row_idx_q, col_idx_q);
              valida_d  = 1'b1;
              deb_cnt_d = '0;
              state_d   = ST_HELD;
            end else begin
              deb_cnt_d = deb_cnt_inc;
            end
          end else begin
            // Bounce: give up on this key and carry on scanning.
            deb_cnt_d = '0;
            fila_d    = rotate_row(fila_q);
            state_d   = ST_SCAN;
          end
        end

        ST_HELD: begin
          if (!captured_low) begin
            if (DEB_IMMEDIATE) begin
              deb_cnt_d = '0;
              fila_d    = rotate_row(fila_q);
              state_d   = ST_SCAN;
            end else begin
              deb_cnt_d = DEB_ONE;
              state_d   = ST_DEB_RELEASE;
            end
          end
        end

        ST_DEB_RELEASE: begin
          if (!captured_low) begin
            if (deb_cnt_inc == DEB_LAST) begin
              deb_cnt_d = '0;
              fila_d    = rotate_row(fila_q);
              state_d   = ST_SCAN;
            end else begin
              deb_cnt_d = deb_cnt_inc;
            end
          end else begin
            deb_cnt_d = '0;
            state_d   = ST_HELD;
          end
        end

        default: begin
          state_d   = ST_SCAN;
          deb_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_Fila       = fila_q;
    o_Tecla      = tecla_q;
    o_Valida     = valida_q;
    o_Presionada = (state_q == ST_HELD) || (state_q == ST_DEB_RELEASE);
  end

endmodule : keypad_scanner

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// A keypad model pulls a column low whenever a pressed key's row is driven.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  fila;
  logic [3:0]  tecla;
  logic        valida;
  logic        pres;
  logic [15:0] key_mask;

  int n_vec;
  int n_err;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_Columna    (col),
    .o_Fila       (fila),
    .o_Tecla      (tecla),
    .o_Valida     (valida),
    .o_Presionada (pres)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model: key r*4+c connects row r to column c.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!fila[r] && key_mask[r*4+c]) begin
          col[c] = 1'b0;
        end
      end
    end
  end

  typedef struct {
    bit          do_rst;
    logic [15:0] mask;
    int          ticks;
    logic [3:0]  fila;
    logic [3:0]  tecla;
    logic        pres;
    int          vcnt;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run n scan ticks (4 clocks each), counting o_Valida cycles.
  task automatic run_ticks(input int n, output int vc);
    vc = 0;
    repeat (n * 4) begin
      @(posedge clk);
      #1;
      if (valida) vc++;
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ef, input logic [3:0] et,
                            input logic ep, input int ev, input int vc);
    check({tag, "_fila"},  32'(fila),  32'(ef));
    check({tag, "_tecla"}, 32'(tecla), 32'(et));
    check({tag, "_pres"},  32'(pres),  32'(ep));
    check({tag, "_valid"}, 32'(vc),    32'(ev));
    $display("%s: fila=%b tecla=%0d pres=%b valid_pulses=%0d", tag, fila, tecla, pres, vc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         vc;
    logic [3:0] exp_f;

    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    key_mask = 16'h0000;

    // Idle scanning straight out of reset: each row held 4 clocks.
    do_reset();
    #1;
    check("rst_fila",  32'(fila),   32'(4'b1110));
    check("rst_tecla", 32'(tecla),  32'd0);
    check("rst_valid", 32'(valida), 32'd0);
    check("rst_pres",  32'(pres),   32'd0);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      exp_f = ~(4'b0001 << ((k / 4) % 4));
      check("idle_fila",  32'(fila),   32'(exp_f));
      check("idle_valid", 32'(valida), 32'd0);
    end
    $display("idle scan: 64 cycles checked");

    // Key codes: row2/col1 = bit 9, row1/col0 = bit 4, row1/col1 = bit 5, row1/col2 = bit 6
    tbl[0] = '{1'b1, 16'h0000,  0, 4'b1110, 4'd0, 1'b0, 0}; // reset state
    tbl[1] = '{1'b0, 16'h0000, 16, 4'b1110, 4'd0, 1'b0, 0}; // four full idle rotations
    tbl[2] = '{1'b0, 16'h0200,  5, 4'b1011, 4'd9, 1'b1, 1}; // row2 col1 accepted
    tbl[3] = '{1'b0, 16'h0200,  4, 4'b1011, 4'd9, 1'b1, 0}; // held, row frozen
    tbl[4] = '{1'b0, 16'h0000,  1, 4'b1011, 4'd9, 1'b1, 0}; // release debouncing
    tbl[5] = '{1'b0, 16'h0000,  2, 4'b0111, 4'd9, 1'b0, 0}; // release accepted, advance
    tbl[6] = '{1'b0, 16'h0050,  5, 4'b1101, 4'd4, 1'b1, 1}; // cols 0+2 on row1 -> 4
    tbl[7] = '{1'b0, 16'h0070,  3, 4'b1101, 4'd4, 1'b1, 0}; // extra key ignored
    tbl[8] = '{1'b0, 16'h0040,  3, 4'b1011, 4'd4, 1'b0, 0}; // col0 released, col2 ignored
    tbl[9] = '{1'b0, 16'h0000,  1, 4'b0111, 4'd4, 1'b0, 0}; // scanning continues

    for (int i = 0; i < 10; i++) begin
      key_mask = 16'h0000;
      if (tbl[i].do_rst) do_reset();
      key_mask = tbl[i].mask;
      vc = 0;
      if (tbl[i].ticks > 0) run_ticks(tbl[i].ticks, vc);
      else #1;
      check_outs($sformatf("vec%0d", i), tbl[i].fila, tbl[i].tecla, tbl[i].pres, tbl[i].vcnt, vc);
    end

    // Bounce: row3/col3 seen once, then high on the second debounce tick.
    key_mask = 16'h8000;
    run_ticks(1, vc);
    check_outs("bounce_deb", 4'b0111, 4'd4, 1'b0, 0, vc);
    key_mask = 16'h0000;
    run_ticks(1, vc);
    check_outs("bounce_abort", 4'b1110, 4'd4, 1'b0, 0, vc);
    run_ticks(1, vc);
    check_outs("bounce_scan", 4'b1101, 4'd4, 1'b0, 0, vc);

    // Reset in the middle of DEB_PRESS for row1/col3 (code 7).
    key_mask = 16'h0080;
    run_ticks(2, vc);
    check_outs("rstdeb_pre", 4'b1101, 4'd4, 1'b0, 0, vc);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstdeb_async_fila",  32'(fila),   32'(4'b1110));
    check("rstdeb_async_tecla", 32'(tecla),  32'd0);
    check("rstdeb_async_valid", 32'(valida), 32'd0);
    check("rstdeb_async_pres",  32'(pres),   32'd0);
    $display("rstdeb_async: fila=%b tecla=%0d valid=%b pres=%b", fila, tecla, valida, pres);
    repeat (3) @(posedge clk);
    #1;
    check("rstdeb_hold_fila", 32'(fila), 32'(4'b1110));
    @(negedge clk);
    rst_n = 1'b1;
    run_ticks(1, vc);
    check_outs("rstdeb_row1", 4'b1101, 4'd0, 1'b0, 0, vc);
    run_ticks(2, vc);
    check_outs("rstdeb_redeb", 4'b1101, 4'd0, 1'b0, 0, vc);
    run_ticks(1, vc);
    check_outs("rstdeb_accept", 4'b1101, 4'd7, 1'b1, 1, vc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_keypad_scanner
